// File: rtl/tx_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_fsm_pkg
// Description : Shared state encoding and helper function for the
//               transaction-layer flow-control supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_fsm_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_RESET  = 3'd0;
    localparam logic [ST_W-1:0] ST_INIT   = 3'd1;
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd2;
    localparam logic [ST_W-1:0] ST_ACTIVE = 3'd3;
    localparam logic [ST_W-1:0] ST_ERROR  = 3'd4;

    // Index of the lowest set bit; 0 when no bit is set. Sized for the
    // largest supported FIFO count so callers zero-extend and truncate.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_idle_hyst.sv
`default_nettype none
// ============================================================================
// Module      : tx_idle_hyst
// Description : Saturating counter of consecutive all-empty cycles. Flags
//               the cycle on which the count would reach IDLE_HOLD.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_idle_hyst #(
    parameter int IDLE_HOLD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_all_empty,
    output logic o_hold_done
);

    localparam int               CNT_W  = $clog2(IDLE_HOLD + 1);
    localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(IDLE_HOLD);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(IDLE_HOLD - 1);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    // Count all-empty cycles while enabled; any busy or disabled cycle restarts.
    always_comb begin
        w_cnt_d = '0;
        if (i_en && i_all_empty) begin
            w_cnt_d = (r_cnt_q == C_HOLD) ? C_HOLD : r_cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_hold_done = i_en & i_all_empty & (r_cnt_q >= C_LAST);

endmodule
`default_nettype wire

// File: rtl/tx_flow_fsm_param.sv
`default_nettype none
// ============================================================================
// Module      : tx_flow_fsm_param
// Description : Flow-control supervisor for NUM_FIFOS transaction-layer
//               FIFOs: threshold latching during INIT, idle hysteresis,
//               masked sticky error capture with first-failing index.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_flow_fsm_param
    import tx_fsm_pkg::*;
#(
    parameter int NUM_FIFOS = 5,
    parameter int U_MFS     = 4,
    parameter int U_VCS     = 4,
    parameter int U_DS      = 4,
    parameter int IDLE_HOLD = 2,
    localparam int IDX_W    = $clog2(NUM_FIFOS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [U_MFS-1:0]     umbral_MFs,
    input  logic [U_VCS-1:0]     umbral_VCs,
    input  logic [U_DS-1:0]      umbral_Ds,
    input  logic [NUM_FIFOS-1:0] FIFO_empties,
    input  logic [NUM_FIFOS-1:0] FIFO_errors,
    input  logic [NUM_FIFOS-1:0] error_mask,
    input  logic                 error_clear,
    output logic [U_MFS-1:0]     umbral_MFs_out,
    output logic [U_VCS-1:0]     umbral_VCs_out,
    output logic [U_DS-1:0]      umbral_Ds_out,
    output logic [ST_W-1:0]      present_state,
    output logic [ST_W-1:0]      next_state,
    output logic                 idle_out,
    output logic                 active_out,
    output logic                 error_out,
    output logic [NUM_FIFOS-1:0] error_vec,
    output logic [IDX_W-1:0]     error_idx
);

    logic [ST_W-1:0]      r_state_q;
    logic [ST_W-1:0]      w_state_d;
    logic [NUM_FIFOS-1:0] w_err_now;
    logic [IDX_W-1:0]     w_err_idx;
    logic                 w_all_empty;
    logic                 w_thr_valid;
    logic                 w_hold_done;
    logic [U_MFS-1:0]     r_mf_q;
    logic [U_VCS-1:0]     r_vc_q;
    logic [U_DS-1:0]      r_d_q;
    logic [NUM_FIFOS-1:0] r_err_vec_q;
    logic [IDX_W-1:0]     r_err_idx_q;

    assign w_err_now   = FIFO_errors & ~error_mask;
    assign w_err_idx   = IDX_W'(lowest_set(16'(w_err_now)));
    assign w_all_empty = &FIFO_empties;
    assign w_thr_valid = (|umbral_MFs) & (|umbral_VCs) & (|umbral_Ds);

    tx_idle_hyst #(
        .IDLE_HOLD (IDLE_HOLD)
    ) u_idle_hyst (
        .clk         (clk),
        .rst         (reset),
        .i_en        (r_state_q == ST_ACTIVE),
        .i_all_empty (w_all_empty),
        .o_hold_done (w_hold_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_RESET;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state selection: reset > error > init > normal flow.
    always_comb begin
        w_state_d = r_state_q;
        if (reset) begin
            w_state_d = ST_RESET;
        end else begin
            case (r_state_q)
                ST_RESET:  w_state_d = ST_INIT;
                ST_INIT: begin
                    if (|w_err_now)                 w_state_d = ST_ERROR;
                    else if (!init && w_thr_valid)  w_state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (|w_err_now)                 w_state_d = ST_ERROR;
                    else if (init)                  w_state_d = ST_INIT;
                    else if (!w_all_empty)          w_state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (|w_err_now)                 w_state_d = ST_ERROR;
                    else if (init)                  w_state_d = ST_INIT;
                    else if (w_hold_done)           w_state_d = ST_IDLE;
                end
                ST_ERROR: begin
                    if (error_clear && !(|w_err_now)) w_state_d = ST_INIT;
                end
                default:                            w_state_d = ST_RESET;
            endcase
        end
    end

    // Threshold latching in INIT and sticky error capture around ERROR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mf_q      <= '0;
            r_vc_q      <= '0;
            r_d_q       <= '0;
            r_err_vec_q <= '0;
            r_err_idx_q <= '0;
        end else begin
            if (r_state_q == ST_INIT) begin
                r_mf_q <= umbral_MFs;
                r_vc_q <= umbral_VCs;
                r_d_q  <= umbral_Ds;
            end
            if (r_state_q != ST_ERROR && w_state_d == ST_ERROR) begin
                r_err_vec_q <= w_err_now;
                r_err_idx_q <= w_err_idx;
            end else if (r_state_q == ST_ERROR) begin
                if (w_state_d == ST_INIT) begin
                    r_err_vec_q <= '0;
                    r_err_idx_q <= '0;
                end else begin
                    r_err_vec_q <= r_err_vec_q | w_err_now;
                end
            end
        end
    end

    // Moore status decode and output wiring.
    always_comb begin
        present_state  = r_state_q;
        next_state     = w_state_d;
        idle_out       = (r_state_q == ST_IDLE);
        active_out     = (r_state_q == ST_ACTIVE);
        error_out      = (r_state_q == ST_ERROR);
        umbral_MFs_out = r_mf_q;
        umbral_VCs_out = r_vc_q;
        umbral_Ds_out  = r_d_q;
        error_vec      = r_err_vec_q;
        error_idx      = r_err_idx_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_flow_fsm_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_flow_fsm_param
// Description : Directed and randomized self-checking bench for
//               tx_flow_fsm_param against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_flow_fsm_param;

    localparam int NUM_FIFOS = 5;
    localparam int U_MFS     = 4;
    localparam int U_VCS     = 4;
    localparam int U_DS      = 4;
    localparam int IDLE_HOLD = 2;
    localparam int IDX_W     = $clog2(NUM_FIFOS);

    logic                 clk = 1'b0;
    logic                 reset, init, error_clear;
    logic [U_MFS-1:0]     umbral_MFs;
    logic [U_VCS-1:0]     umbral_VCs;
    logic [U_DS-1:0]      umbral_Ds;
    logic [NUM_FIFOS-1:0] FIFO_empties, FIFO_errors, error_mask;
    logic [U_MFS-1:0]     umbral_MFs_out;
    logic [U_VCS-1:0]     umbral_VCs_out;
    logic [U_DS-1:0]      umbral_Ds_out;
    logic [2:0]           present_state, next_state;
    logic                 idle_out, active_out, error_out;
    logic [NUM_FIFOS-1:0] error_vec;
    logic [IDX_W-1:0]     error_idx;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: state as integer (0 RESET,1 INIT,2 IDLE,3 ACTIVE,4 ERROR)
    int                   m_state = 0;
    int                   m_run   = 0;
    logic [U_MFS-1:0]     m_mf  = '0;
    logic [U_VCS-1:0]     m_vc  = '0;
    logic [U_DS-1:0]      m_d   = '0;
    logic [NUM_FIFOS-1:0] m_vec = '0;
    logic [IDX_W-1:0]     m_idx = '0;

    always #5 clk = ~clk;

    tx_flow_fsm_param #(
        .NUM_FIFOS (NUM_FIFOS), .U_MFS (U_MFS), .U_VCS (U_VCS),
        .U_DS (U_DS), .IDLE_HOLD (IDLE_HOLD)
    ) dut (
        .clk (clk), .reset (reset), .init (init),
        .umbral_MFs (umbral_MFs), .umbral_VCs (umbral_VCs), .umbral_Ds (umbral_Ds),
        .FIFO_empties (FIFO_empties), .FIFO_errors (FIFO_errors),
        .error_mask (error_mask), .error_clear (error_clear),
        .umbral_MFs_out (umbral_MFs_out), .umbral_VCs_out (umbral_VCs_out),
        .umbral_Ds_out (umbral_Ds_out), .present_state (present_state),
        .next_state (next_state), .idle_out (idle_out), .active_out (active_out),
        .error_out (error_out), .error_vec (error_vec), .error_idx (error_idx)
    );

    function automatic logic [IDX_W-1:0] ref_lowest(input logic [NUM_FIFOS-1:0] v);
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (v[i]) return IDX_W'(i);
        end
        return '0;
    endfunction

    function automatic int ref_next();
        logic [NUM_FIFOS-1:0] err;
        err = FIFO_errors & ~error_mask;
        if (reset) return 0;
        case (m_state)
            0: return 1;
            1: if (err != 0) return 4;
               else if (!init && umbral_MFs != 0 && umbral_VCs != 0 && umbral_Ds != 0) return 2;
               else return 1;
            2: if (err != 0) return 4;
               else if (init) return 1;
               else if (FIFO_empties != {NUM_FIFOS{1'b1}}) return 3;
               else return 2;
            3: if (err != 0) return 4;
               else if (init) return 1;
               else if (FIFO_empties == {NUM_FIFOS{1'b1}} && m_run + 1 >= IDLE_HOLD) return 2;
               else return 3;
            4: if (error_clear && err == 0) return 1;
               else return 4;
            default: return 0;
        endcase
    endfunction

    // Advance the model using the current inputs, then clock the DUT.
    task automatic step();
        logic [NUM_FIFOS-1:0] err;
        int ns;
        err = FIFO_errors & ~error_mask;
        ns  = ref_next();
        if (reset) begin
            m_mf = '0; m_vc = '0; m_d = '0; m_vec = '0; m_idx = '0; m_run = 0;
        end else begin
            if (m_state == 1) begin
                m_mf = umbral_MFs; m_vc = umbral_VCs; m_d = umbral_Ds;
            end
            if (m_state == 3) m_run = (FIFO_empties == {NUM_FIFOS{1'b1}}) ? m_run + 1 : 0;
            if (ns == 4 && m_state != 4) begin
                m_vec = err;
                m_idx = ref_lowest(err);
            end else if (m_state == 4) begin
                if (ns == 1) begin
                    m_vec = '0; m_idx = '0;
                end else begin
                    m_vec = m_vec | err;
                end
            end
            if (ns != 3) m_run = 0;
        end
        m_state = ns;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b0; error_clear = 1'b0;
        umbral_MFs = '0; umbral_VCs = '0; umbral_Ds = '0;
        FIFO_empties = '1; FIFO_errors = '0; error_mask = '0;
        #1;
        n_checks++;
        if (next_state !== 3'd0) begin
            n_bad++; $display("FAIL reset_next: got %0d want 0", next_state);
        end
        step(); step();
        n_checks++;
        if ({present_state, umbral_MFs_out, umbral_VCs_out, umbral_Ds_out, error_vec, error_idx,
             idle_out, active_out, error_out} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: state=%0d thr=%0h/%0h/%0h vec=%b idx=%0d want all 0",
                              present_state, umbral_MFs_out, umbral_VCs_out, umbral_Ds_out, error_vec, error_idx);
        end
    endtask

    task automatic test_init_config();
        reset = 1'b0; init = 1'b1;
        umbral_MFs = 4'd14; umbral_VCs = 4'd7; umbral_Ds = 4'd9;
        step();
        n_checks++;
        if (present_state !== 3'd1) begin
            n_bad++; $display("FAIL init_entry: got %0d want 1", present_state);
        end
        step();
        init = 1'b0;
        step();
        n_checks++;
        if (present_state !== 3'd2 || idle_out !== 1'b1) begin
            n_bad++; $display("FAIL init_to_idle: state=%0d idle=%b want 2/1", present_state, idle_out);
        end
        n_checks++;
        if ({umbral_MFs_out, umbral_VCs_out, umbral_Ds_out} !== {4'd14, 4'd7, 4'd9}) begin
            n_bad++; $display("FAIL thr_latch: got %0d/%0d/%0d want 14/7/9",
                              umbral_MFs_out, umbral_VCs_out, umbral_Ds_out);
        end
    endtask

    task automatic test_zero_threshold();
        init = 1'b1;
        step();
        init = 1'b0; umbral_VCs = 4'd0;
        step(); step();
        n_checks++;
        if (present_state !== 3'd1) begin
            n_bad++; $display("FAIL zero_thr_hold: got %0d want 1", present_state);
        end
        umbral_VCs = 4'd1;
        step();
        n_checks++;
        if (present_state !== 3'd2 || umbral_VCs_out !== 4'd1) begin
            n_bad++; $display("FAIL zero_thr_release: state=%0d vc=%0d want 2/1", present_state, umbral_VCs_out);
        end
    endtask

    task automatic test_idle_hyst();
        logic [NUM_FIFOS-1:0] pat [12];
        int                   exp [12];
        pat = '{5'b11011, 5'b11011, 5'b11011, 5'b11111, 5'b11111, 5'b11011,
                5'b11111, 5'b11011, 5'b11111, 5'b11111, 5'b11011, 5'b11011};
        exp = '{3, 3, 3, 3, 2, 3, 3, 3, 3, 2, 3, 3};
        for (int i = 0; i < 12; i++) begin
            FIFO_empties = pat[i];
            step();
            n_checks++;
            if (present_state !== 3'(exp[i])) begin
                n_bad++; $display("FAIL idle_hyst[%0d]: got %0d want %0d", i, present_state, exp[i]);
            end
        end
    endtask

    task automatic test_error_capture();
        FIFO_errors = 5'b10100; error_mask = 5'b00100;
        #1;
        n_checks++;
        if (next_state !== 3'd4) begin
            n_bad++; $display("FAIL err_next: got %0d want 4", next_state);
        end
        step();
        n_checks++;
        if (present_state !== 3'd4 || error_out !== 1'b1 || error_vec !== 5'b10000 || error_idx !== 3'd4) begin
            n_bad++; $display("FAIL err_entry: state=%0d vec=%b idx=%0d want 4/10000/4",
                              present_state, error_vec, error_idx);
        end
        FIFO_errors = 5'b00001;
        step();
        n_checks++;
        if (error_vec !== 5'b10001 || error_idx !== 3'd4) begin
            n_bad++; $display("FAIL err_sticky: vec=%b idx=%0d want 10001/4", error_vec, error_idx);
        end
    endtask

    task automatic test_error_clear();
        error_clear = 1'b1;
        step();
        n_checks++;
        if (present_state !== 3'd4) begin
            n_bad++; $display("FAIL clear_blocked: got %0d want 4", present_state);
        end
        FIFO_errors = '0;
        step();
        n_checks++;
        if (present_state !== 3'd1 || error_vec !== '0 || error_idx !== '0) begin
            n_bad++; $display("FAIL clear_exit: state=%0d vec=%b idx=%0d want 1/0/0",
                              present_state, error_vec, error_idx);
        end
        n_checks++;
        if ({umbral_MFs_out, umbral_VCs_out, umbral_Ds_out} !== {4'd14, 4'd1, 4'd9}) begin
            n_bad++; $display("FAIL clear_thr: got %0d/%0d/%0d want 14/1/9",
                              umbral_MFs_out, umbral_VCs_out, umbral_Ds_out);
        end
        error_clear = 1'b0; error_mask = '0;
        FIFO_errors = 5'b01000;
        step();
        error_mask = 5'b01000;
        step();
        n_checks++;
        if (present_state !== 3'd4 || error_vec !== 5'b01000 || error_idx !== 3'd3) begin
            n_bad++; $display("FAIL mask_in_error: state=%0d vec=%b idx=%0d want 4/01000/3",
                              present_state, error_vec, error_idx);
        end
        error_clear = 1'b1;
        step();
        error_clear = 1'b0; error_mask = '0; FIFO_errors = '0;
    endtask

    task automatic test_back_to_back();
        step();
        FIFO_empties = 5'b11011;
        step();
        n_checks++;
        if (present_state !== 3'd3) begin
            n_bad++; $display("FAIL b2b_active: got %0d want 3", present_state);
        end
        init = 1'b1; FIFO_errors = 5'b00010;
        step();
        n_checks++;
        if (present_state !== 3'd4 || error_idx !== 3'd1 || error_vec !== 5'b00010) begin
            n_bad++; $display("FAIL b2b_err_over_init: state=%0d vec=%b idx=%0d want 4/00010/1",
                              present_state, error_vec, error_idx);
        end
        reset = 1'b1; error_clear = 1'b1;
        #1;
        n_checks++;
        if (next_state !== 3'd0) begin
            n_bad++; $display("FAIL b2b_reset_next: got %0d want 0", next_state);
        end
        step();
        n_checks++;
        if ({present_state, umbral_MFs_out, umbral_VCs_out, umbral_Ds_out, error_vec, error_idx,
             idle_out, active_out, error_out} !== '0) begin
            n_bad++; $display("FAIL b2b_reset_outputs: state=%0d vec=%b idx=%0d want all 0",
                              present_state, error_vec, error_idx);
        end
        reset = 1'b0; init = 1'b0; FIFO_errors = '0; error_clear = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] exp_ns;
        for (int c = 0; c < 400; c++) begin
            reset       = ($urandom_range(0, 31) == 0);
            init        = ($urandom_range(0, 7) == 0);
            umbral_MFs  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            umbral_VCs  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            umbral_Ds   = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            FIFO_empties = ($urandom_range(0, 1) == 0) ? '1 : NUM_FIFOS'($urandom);
            FIFO_errors  = ($urandom_range(0, 11) == 0) ? NUM_FIFOS'($urandom) : '0;
            error_mask   = ($urandom_range(0, 9) < 7) ? '0 : NUM_FIFOS'($urandom);
            error_clear  = ($urandom_range(0, 2) == 0);
            #1;
            exp_ns = 3'(ref_next());
            n_checks++;
            if (next_state !== exp_ns) begin
                n_bad++; $display("FAIL rand_next[%0d]: got %0d want %0d", c, next_state, exp_ns);
            end
            step();
            n_checks++;
            if ({present_state, umbral_MFs_out, umbral_VCs_out, umbral_Ds_out, error_vec, error_idx,
                 idle_out, active_out, error_out} !==
                {3'(m_state), m_mf, m_vc, m_d, m_vec, m_idx,
                 m_state == 2, m_state == 3, m_state == 4}) begin
                n_bad++; $display("FAIL rand_out[%0d]: state=%0d thr=%0d/%0d/%0d vec=%b idx=%0d want state=%0d thr=%0d/%0d/%0d vec=%b idx=%0d",
                                  c, present_state, umbral_MFs_out, umbral_VCs_out, umbral_Ds_out,
                                  error_vec, error_idx, m_state, m_mf, m_vc, m_d, m_vec, m_idx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_config();
        test_zero_threshold();
        test_idle_hyst();
        test_error_capture();
        test_error_clear();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
